// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared arithmetic definitions for the small multiplier/adder slice.
//   MUL_W   : operand width of the shift-add multiplier (matches fa4_inst)
//   PROD_W  : product width
//   state_t : multiplier FSM encoding (2'd3 is illegal, recovers to IDLE)
//   pp_sel  : partial-product select (multiplier bit gates the multiplicand)
// -----------------------------------------------------------------------------
package arith_pkg;

   localparam int MUL_W  = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Partial product for one iteration: the multiplicand when the current
   // multiplier bit is set, otherwise zero.
   function automatic logic [MUL_W-1:0] pp_sel(input logic bit_i,
                                              input logic [MUL_W-1:0] mcand_i);
      logic [MUL_W-1:0] r;
      if (bit_i) begin
         r = mcand_i;
      end else begin
         r = 4'h0;
      end
      return r;
   endfunction

endpackage

// File: rtl/fa4_inst.sv
// -----------------------------------------------------------------------------
// fa4_inst
// 4-bit ripple-carry adder built from four full-adder stages.
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
// -----------------------------------------------------------------------------
module fa4_inst (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] carry_s;

   assign carry_s[0] = ci;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_stage
         assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
         assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign co = carry_s[4];

endmodule

// File: rtl/mul4_seq.sv
// -----------------------------------------------------------------------------
// mul4_seq
// Sequential 4x4 unsigned shift-add multiplier. One add-and-shift per cycle
// through fa4_inst, four iterations, then the 8-bit product is published.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, accepted in IDLE or DONE
//   a, b  : multiplicand / multiplier, captured when start is accepted
//   busy  : high while iterating (RUN)
//   done  : one-cycle pulse when p has just been updated
//   p     : product register, holds between completions
// -----------------------------------------------------------------------------
module mul4_seq
   import arith_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] p
);

   state_t     state_r;
   state_t     state_nx_s;

   logic [3:0] mcand_r;
   // Low 8 bits of the 9-bit accumulator; bit 8 is always zero after the
   // shift, so it is not stored.
   logic [7:0] acc_r;
   logic [1:0] cnt_r;
   logic       busy_r;
   logic       done_r;
   logic [7:0] p_r;

   logic       load_s;
   logic       step_s;
   logic       last_s;
   logic       busy_nx_s;
   logic       done_nx_s;

   logic [3:0] addend_s;
   logic [3:0] sum_s;
   logic       c_s;
   logic [7:0] acc_nx_s;

   // Shift-add datapath: upper accumulator nibble plus gated multiplicand.
   assign addend_s = pp_sel(acc_r[0], mcand_r);

   fa4_inst u_fa4 (
      .a  (acc_r[7:4]),
      .b  (addend_s),
      .ci (1'b0),
      .s  (sum_s),
      .co (c_s)
   );

   // Right shift of {c, sum, acc[3:0]}; the dropped LSB is the consumed
   // multiplier bit and the carry lands in bit 7.
   assign acc_nx_s = {c_s, sum_s, acc_r[3:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      state_nx_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == 2'd3) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Control decode: operand load, iteration step, final iteration and the
   // next values of the registered status outputs.
   always_comb begin
      load_s    = 1'b0;
      step_s    = 1'b0;
      last_s    = 1'b0;
      busy_nx_s = (state_nx_s == ST_RUN);
      done_nx_s = (state_nx_s == ST_DONE);
      case (state_r)
         ST_IDLE: begin
            load_s = start;
         end
         ST_DONE: begin
            load_s = start;
         end
         ST_RUN: begin
            step_s = 1'b1;
            last_s = (cnt_r == 2'd3);
         end
         default: begin
            load_s = 1'b0;
         end
      endcase
   end

   // Operand, accumulator and iteration counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r <= 4'h0;
         acc_r   <= 8'h00;
         cnt_r   <= 2'd0;
      end else if (load_s) begin
         mcand_r <= a;
         acc_r   <= {4'h0, b};
         cnt_r   <= 2'd0;
      end else if (step_s) begin
         acc_r   <= acc_nx_s;
         cnt_r   <= cnt_r + 2'd1;
      end else begin
         mcand_r <= mcand_r;
         acc_r   <= acc_r;
         cnt_r   <= cnt_r;
      end
   end

   // Product register: updated only on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r <= 8'h00;
      end else if (last_s) begin
         p_r <= acc_nx_s;
      end else begin
         p_r <= p_r;
      end
   end

   // Registered status flags, aligned with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_nx_s;
         done_r <= done_nx_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign p    = p_r;

endmodule

// File: doc/mul4_seq.md
# mul4_seq

Sequential 4x4 unsigned shift-add multiplier that feeds operands into the team's 4-bit ripple adder (`fa4_inst`) over four cycles and produces an 8-bit product. It sits directly on top of the adder stage, reusing it as its only arithmetic datapath. It takes operands under a start/done handshake and holds the result until the next completion.

## Interface
- No parameters. Width is fixed at 4 bits to match `fa4_inst`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a` input 4: multiplicand, unsigned, captured on accepted start.
- `b` input 4: multiplier, unsigned, captured on accepted start.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when `p` is updated.
- `p` output 8: product register; holds its value between completions.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `p`=8'h00. Internal registers are `mcand`=0, `acc`=9'h000 and `cnt`=0.
- **IDLE**
  - `start`=1: load `mcand`<=`a`, `acc`<={1'b0, 4'h0, `b`}, `cnt`<=0, then go to RUN.
  - Otherwise stay in IDLE.
- **RUN** (every cycle)
  - `fa4_inst` computes `{c, sum}` = `acc[7:4]` + (`acc[0]` ? `mcand` : 4'h0) + 0.
  - Then `acc`<={1'b0, c, sum, `acc[3:1]`}, i.e. a right shift of the 9-bit value `{c, sum, acc[3:0]}`.
  - `cnt`<=`cnt`+1.
  - When `cnt`==3 this is the final iteration: `p`<=next `acc[7:0]`, then go to DONE.
- **DONE**
  - `done`=1 for this cycle only; `p` is valid.
  - `start`=1: accept new operands exactly as in IDLE and go to RUN, which supports back-to-back operation.
  - Otherwise go to IDLE.
- `start` during RUN is ignored. Operands are not re-sampled and the cycle count is unaffected.
- `a`/`b` are don't-care except in the cycle where `start` is accepted.
- Arithmetic: the adder carry is kept as bit 8 before the shift, so no overflow is possible. The maximum product is 15*15=225=8'hE1.
- `cnt` is 2 bits and wraps 3->0. The wrap is never observed, because leaving RUN reloads `cnt`.
- `rst_n` low at any time, including mid-RUN, immediately forces all reset values. The in-flight result is discarded and `p` clears to 0.

## Timing
- Cycle 0: `start`=1 in IDLE or DONE.
- Cycles 1–4: `busy`=1, one iteration per cycle.
- Cycle 5: `done`=1, `busy`=0, `p`=a*b.
- Latency is 5 cycles from the start edge to `done`. Throughput is one result per 5 cycles when back-to-back.
- `p` changes only on the edge entering DONE, or on reset.
- `busy` and `done` are registered, decoded from the state register with no combinational path from `start`.
- Adder path per cycle: the `fa4_inst` ripple (4 stages) plus a 4-bit mux. No other arithmetic sits in the path.

## Structure
- Shared package `arith_pkg` holds:
  - `MUL_W`=4 and `PROD_W`=8;
  - state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - 2'd3 is illegal and decodes to IDLE on the next edge.
- One sub-module: `fa4_inst`, instantiated once as the shift-add adder with `ci` tied to 0.
- FSM, counter and shift register are in `mul4_seq` itself.

## Test plan
- Reset then a=4'hF, b=4'hF, `start` pulse -> `busy` high cycles 1–4, `done` cycle 5, `p`=8'hE1; `p` holds 8'hE1 for the following 10 idle cycles.
- a=4'h0, b=4'h9, then a=4'h9, b=4'h0 -> `p`=8'h00 both times, with `done` asserted on each.
- Back-to-back: a=9, b=7 (start held) -> `p`=8'h3F at cycle 5; second start accepted in DONE with a=3, b=5 -> `p`=8'h0F at cycle 10; no IDLE cycle between.
- `start` toggled with a=1, b=1 during cycles 2–3 of a 6*5 operation -> `p`=8'h1E at cycle 5, no extra `done`, no restart.
- `rst_n` asserted low asynchronously in cycle 3 of a 12*12 operation -> `busy`/`done`/`p` go to 0 immediately; after release a fresh 2*3 yields `p`=8'h06.
- Exhaustive: all 256 a/b pairs back-to-back -> every `p`==a*b, every `done` exactly 5 cycles after its start.
